// File: rtl/rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// rgb_pwm_driver
//
// Turns the packed 24-bit `light` colour word into three PWM pins that drive a
// discrete RGB LED. A prescaler divides clk down to the PWM count rate. An
// 8-bit counter sweeps 0..255 once per period. Each channel is high while the
// counter is below that channel's latched duty.
//
// Duty values are latched only at the counter wrap, or continuously while the
// driver is disabled. A colour change from upstream therefore never cuts into
// a period that is already running. The first period after enable rises uses
// the colour that was present on the last disabled cycle.
//
// Optional feature (macro RGB_PWM_GAMMA_EN):
//   defined   : latched duty = (c*c) >> 8, a gamma ~2 perceptual curve
//   undefined : latched duty = c, linear
//
// Parameters:
//   PRESCALE    clk cycles per PWM count step (>= 1)
//   CNT_W       PWM counter width, equal to the colour field width (8)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   light[23:0]  packed colour: [23:16] red, [15:8] green, [7:0] blue
//   enable       1 = PWM running; 0 = pins low, counters held at zero
//   red          registered red PWM drive
//   green        registered green PWM drive
//   blue         registered blue PWM drive
//   period_done  single-cycle pulse when the PWM counter wraps
// -----------------------------------------------------------------------------
module rgb_pwm_driver #(
   parameter int PRESCALE = 1,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3*CNT_W-1:0] light,
   input  logic              enable,
   output logic              red,
   output logic              green,
   output logic              blue,
   output logic              period_done
);

   // The prescale counter needs at least one bit even when PRESCALE is 1.
   // In that case it sits at zero and every cycle is a tick.
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Map a raw colour field to the duty that gets latched. With gamma enabled
   // the square is taken at double width and its upper half is kept. That way
   // full scale (255) lands on 254 and small values collapse towards zero.
   function automatic logic [CNT_W-1:0] shape_duty(input logic [CNT_W-1:0] c);
`ifdef RGB_PWM_GAMMA_EN
      logic [2*CNT_W-1:0] sq;
      sq = (2*CNT_W)'(c) * (2*CNT_W)'(c);
      return sq[2*CNT_W-1:CNT_W];
`else
      return c;
`endif
   endfunction

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [CNT_W-1:0] duty_r_q, duty_r_d;
   logic [CNT_W-1:0] duty_g_q, duty_g_d;
   logic [CNT_W-1:0] duty_b_q, duty_b_d;
   logic             red_q, red_d;
   logic             green_q, green_d;
   logic             blue_q, blue_d;
   logic             period_done_q, period_done_d;

   logic             tick;
   logic             wrap;
   logic             load_duty;

   // Timing events. A tick marks the last clk cycle of one count step. The
   // wrap is the tick on which the counter leaves 255. That makes it the last
   // cycle of a PWM period and the only point where a new colour is taken
   // while running.
   always_comb begin
      tick      = (pre_cnt_q == PRE_MAX);
      wrap      = tick && (pwm_cnt_q == CNT_MAX);
      load_duty = wrap || !enable;
   end

   // Counter next state. Disabling parks both counters at zero. When enable
   // returns, the first period then starts cleanly at count 0. The PWM
   // counter relies on natural modulo-2^CNT_W wrap.
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      pwm_cnt_d = pwm_cnt_q;
      if (!enable) begin
         pre_cnt_d = '0;
         pwm_cnt_d = '0;
      end else if (tick) begin
         pre_cnt_d = '0;
         pwm_cnt_d = pwm_cnt_q + 1'b1;
      end else begin
         pre_cnt_d = pre_cnt_q + 1'b1;
      end
   end

   // Duty latch. The light fields are sampled on the same edge that wraps the
   // counter, or on every edge while disabled. If light changes on the wrap
   // cycle itself, the new value is the one captured.
   always_comb begin
      duty_r_d = duty_r_q;
      duty_g_d = duty_g_q;
      duty_b_d = duty_b_q;
      if (load_duty) begin
         duty_r_d = shape_duty(light[3*CNT_W-1:2*CNT_W]);
         duty_g_d = shape_duty(light[2*CNT_W-1:CNT_W]);
         duty_b_d = shape_duty(light[CNT_W-1:0]);
      end
   end

   // Pin compare, taken from the pre-edge counter and duty. This gives one
   // cycle of latency from counter to pin. A duty of 255 can never reach
   // 100% because the counter also visits 255 itself. The period strobe is
   // suppressed while disabled.
   always_comb begin
      red_d         = enable && (pwm_cnt_q < duty_r_q);
      green_d       = enable && (pwm_cnt_q < duty_g_q);
      blue_d        = enable && (pwm_cnt_q < duty_b_q);
      period_done_d = enable && wrap;
   end

   // State registers. Reset is synchronous and overrides everything,
   // including enable and a period that is in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q     <= '0;
         pwm_cnt_q     <= '0;
         duty_r_q      <= '0;
         duty_g_q      <= '0;
         duty_b_q      <= '0;
         red_q         <= 1'b0;
         green_q       <= 1'b0;
         blue_q        <= 1'b0;
         period_done_q <= 1'b0;
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         duty_r_q      <= duty_r_d;
         duty_g_q      <= duty_g_d;
         duty_b_q      <= duty_b_d;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
         period_done_q <= period_done_d;
      end
   end

   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign period_done = period_done_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_driver
//
// Self-checking bench for rgb_pwm_driver. The reference model works in whole
// clk cycles. It tracks how many enabled cycles have passed since the PWM
// period last restarted. A channel is expected high when its position inside
// the 256*PRESCALE-cycle period is below duty*PRESCALE. Directed scenarios
// follow the test plan. A randomized section then mixes light changes,
// enable drops and resets.
// -----------------------------------------------------------------------------
module tb_rgb_pwm_driver;

   localparam int PRESCALE = 3;
   localparam int PERIOD   = 256 * PRESCALE;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [23:0] light;
   logic        red;
   logic        green;
   logic        blue;
   logic        periodDone;

   int compareCount = 0;
   int failCount    = 0;

   int   modelPhase;
   int   modelDuty [3];
   logic expRed, expGreen, expBlue, expDone;

   int highR, highG, highB, pulseCount;

   always #5 clk = ~clk;

   rgb_pwm_driver #(
      .PRESCALE (PRESCALE),
      .CNT_W    (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .light       (light),
      .enable      (enable),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .period_done (periodDone)
   );

   // Colour-to-duty rule written as plain arithmetic.
   function automatic int shapeDuty(input int c);
`ifdef RGB_PWM_GAMMA_EN
      return (c * c) / 256;
`else
      return c;
`endif
   endfunction

   // Advance the reference model by one rising edge, using the inputs that
   // were present before that edge.
   task automatic modelEdge(input logic r, input logic en, input logic [23:0] l);
      int pos;
      if (r) begin
         modelPhase = 0;
         for (int i = 0; i < 3; i++) modelDuty[i] = 0;
         {expRed, expGreen, expBlue, expDone} = 4'b0000;
      end else if (!en) begin
         modelPhase   = 0;
         modelDuty[0] = shapeDuty(int'(l[23:16]));
         modelDuty[1] = shapeDuty(int'(l[15:8]));
         modelDuty[2] = shapeDuty(int'(l[7:0]));
         {expRed, expGreen, expBlue, expDone} = 4'b0000;
      end else begin
         pos      = modelPhase % PERIOD;
         expRed   = (pos < modelDuty[0] * PRESCALE);
         expGreen = (pos < modelDuty[1] * PRESCALE);
         expBlue  = (pos < modelDuty[2] * PRESCALE);
         expDone  = (pos == PERIOD - 1);
         if (expDone) begin
            modelDuty[0] = shapeDuty(int'(l[23:16]));
            modelDuty[1] = shapeDuty(int'(l[15:8]));
            modelDuty[2] = shapeDuty(int'(l[7:0]));
         end
         modelPhase++;
      end
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkCount(input string tag, input int observed, input int expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One clk cycle: drive on the falling edge, let the model follow the rising
   // edge, then sample the DUT 1 time unit later and accumulate pin activity.
   task automatic applyStimulus(input logic r, input logic en, input logic [23:0] l);
      @(negedge clk);
      rst    = r;
      enable = en;
      light  = l;
      @(posedge clk);
      modelEdge(r, en, l);
      #1;
      checkOutput("red",         red,        expRed);
      checkOutput("green",       green,      expGreen);
      checkOutput("blue",        blue,       expBlue);
      checkOutput("period_done", periodDone, expDone);
      highR      += int'(red === 1'b1);
      highG      += int'(green === 1'b1);
      highB      += int'(blue === 1'b1);
      pulseCount += int'(periodDone === 1'b1);
   endtask

   task automatic resetCounts();
      highR      = 0;
      highG      = 0;
      highB      = 0;
      pulseCount = 0;
   endtask

   initial begin
      logic [23:0] rndLight;
      logic        rndRst;
      logic        rndEn;

      rst        = 1'b1;
      enable     = 1'b0;
      light      = 24'h0;
      modelPhase = 0;
      for (int i = 0; i < 3; i++) modelDuty[i] = 0;
      {expRed, expGreen, expBlue, expDone} = 4'b0000;
      resetCounts();

      // Plan 1: reset held with full white and enable high, then one period
      // that must stay dark because the duties were cleared by reset.
      $display("[TB] reset behaviour");
      repeat (3) applyStimulus(1'b1, 1'b1, 24'hFFFFFF);
      checkOutput("rst_red", red, 1'b0);
      checkOutput("rst_done", periodDone, 1'b0);
      resetCounts();
      repeat (PERIOD) applyStimulus(1'b0, 1'b1, 24'hFFFFFF);
      checkCount("p1_red_high",   highR, 0);
      checkCount("p1_blue_high",  highB, 0);
      checkCount("p1_pulses",     pulseCount, 1);
      checkOutput("p1_done_last", periodDone, 1'b1);

      // Plan 2: latch 800040 while disabled, then two full periods.
      $display("[TB] duty latch from disabled state");
      repeat (2) applyStimulus(1'b0, 1'b0, 24'h800040);
      for (int p = 0; p < 2; p++) begin
         resetCounts();
         repeat (PERIOD) applyStimulus(1'b0, 1'b1, 24'h800040);
         checkCount("p2_red_high",   highR, shapeDuty(128) * PRESCALE);
         checkCount("p2_green_high", highG, 0);
         checkCount("p2_blue_high",  highB, shapeDuty(64) * PRESCALE);
         checkCount("p2_pulses",     pulseCount, 1);
      end

      // Plan 3: colour drops to black mid-period; the running period keeps
      // full duty, and the following one goes dark.
      $display("[TB] mid-period colour change");
      applyStimulus(1'b0, 1'b0, 24'hFFFFFF);
      resetCounts();
      repeat (100 * PRESCALE) applyStimulus(1'b0, 1'b1, 24'hFFFFFF);
      repeat (156 * PRESCALE) applyStimulus(1'b0, 1'b1, 24'h000000);
      checkCount("p3_red_high",   highR, shapeDuty(255) * PRESCALE);
      checkCount("p3_green_high", highG, shapeDuty(255) * PRESCALE);
      checkCount("p3_blue_high",  highB, shapeDuty(255) * PRESCALE);
      resetCounts();
      repeat (PERIOD) applyStimulus(1'b0, 1'b1, 24'h000000);
      checkCount("p3_next_high", highR + highG + highB, 0);
      checkCount("p3_next_pulses", pulseCount, 1);

      // Plan 4: reset in the middle of a full-duty period.
      $display("[TB] reset mid-period");
      applyStimulus(1'b0, 1'b0, 24'hFFFFFF);
      repeat (50 * PRESCALE) applyStimulus(1'b0, 1'b1, 24'hFFFFFF);
      applyStimulus(1'b1, 1'b1, 24'hFFFFFF);
      checkOutput("p4_red",   red,        1'b0);
      checkOutput("p4_done",  periodDone, 1'b0);
      checkCount("p4_pwm_cnt", int'(dut.pwm_cnt_q), 0);
      checkCount("p4_duty_r",  int'(dut.duty_r_q), 0);
      resetCounts();
      repeat (PERIOD) applyStimulus(1'b0, 1'b1, 24'hFFFFFF);
      checkCount("p4_after_high", highR + highG + highB, 0);
      checkCount("p4_after_pulses", pulseCount, 1);

      // Randomized traffic: occasional resets, enable drops and colour
      // changes, all checked cycle by cycle against the model.
      $display("[TB] randomized traffic");
      rndLight = 24'($urandom);
      for (int n = 0; n < 4000; n++) begin
         rndRst = ($urandom_range(0, 299) == 0);
         rndEn  = ($urandom_range(0, 199) >= 3);
         if ($urandom_range(0, 19) == 0) rndLight = 24'($urandom);
         applyStimulus(rndRst, rndEn, rndLight);
      end

      // Long enabled stretch with changing colours; one strobe per period.
      rndLight = 24'($urandom);
      applyStimulus(1'b0, 1'b0, rndLight);
      resetCounts();
      for (int n = 0; n < 3 * PERIOD; n++) begin
         if ($urandom_range(0, 36) == 0) rndLight = 24'($urandom);
         applyStimulus(1'b0, 1'b1, rndLight);
      end
      checkCount("rand_pulses", pulseCount, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
